dff_bank: RTL and testbench

Parametrised bank of WIDTH D flip-flops, each with its own active-low preset and clear. It is the cycle-accurate successor to the single preset-only flip-flop used in the I/O mapper simulation. All storage runs on the global system clock. The emulated chip clock is either edge-detected or supplied as a clock-enable strobe. Propagation delays are modelled as whole system-clock cycles, so board-level TTL latches (74ALS74/273-style) can be emulated synthesisably inside the I/O mapper.

---
 rtl/dff_pkg.sv | 35 +++
 rtl/dly_line.sv | 64 ++++++
 rtl/dff_bank.sv | 126 ++++++++++++
 tb/tb_dff_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared types and helpers for the emulated TTL flip-flop bank.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package dff_pkg;

    // Delay counts are whole system-clock cycles and fit in four bits.
    typedef logic [3:0] dly_t;

    localparam dly_t MAX_DLY   = 4'd15;
    localparam int   MAX_WIDTH = 32;

    // Capture source selection for the EDGE_MODE parameter.
    localparam int EDGE   = 1;
    localparam int STROBE = 0;

    // Decoded asynchronous-style override for one channel.
    typedef struct packed {
        logic frc;  // override active, Q/Qn come from q/qn below
        logic q;
        logic qn;
    } ovr_t;

    // Maps the active-low (Sn, Cn) pair onto forced outputs. Both low
    // drives Q and Qn high together, matching the 74ALS74 illegal state.
    // Preset alone pulls Q high and clear alone pulls Qn high, so the
    // forced levels are simply the inverted pins.
    function automatic ovr_t ovr_decode(input logic sn, input logic cn);
        ovr_t o;
        o.frc = ~(sn & cn);
        o.q   = ~sn;
        o.qn  = ~cn;
        return o;
    endfunction

endpackage

// File: rtl/dly_line.sv
// Fixed-depth {valid, data} shift register; DEPTH=0 is a wire-through.
// Latency: DEPTH clk cycles from the sampling edge to the tail.
// Backpressure: none, advances every cycle; flush kills all valid bits.
module dly_line
    import dff_pkg::*;
#(
    parameter int            DEPTH   = 2,
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_DAT = '0
) (
    input  logic         clk,
    input  logic         rn,
    input  logic         flush,
    input  logic         vld,
    input  logic [W-1:0] dat,
    output logic         tail_vld,
    output logic [W-1:0] tail_dat,
    output logic         busy
);

    generate
        if (DEPTH < 0 || DEPTH > int'(MAX_DLY)) begin : g_bad_depth
            $error("dly_line: DEPTH %0d outside 0..%0d", DEPTH, MAX_DLY);
        end

        if (DEPTH == 0) begin : g_pass
            // No storage: clock and reset have nothing to act on.
            logic unused_clk_rn;
            assign unused_clk_rn = clk ^ rn;

            // A flush in the same cycle still cancels the passing entry.
            assign tail_vld = vld & ~flush;
            assign tail_dat = dat;
            assign busy     = 1'b0;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_r;
            logic [W-1:0]     dat_r [DEPTH];

            // Shift one stage per clk; reset and flush clear the valid bits.
            always_ff @(posedge clk) begin
                if (!rn) begin
                    vld_r <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        dat_r[i] <= RST_DAT;
                    end
                end else begin
                    vld_r[0] <= vld & ~flush;
                    dat_r[0] <= dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_r[i] <= vld_r[i-1] & ~flush;
                        dat_r[i] <= dat_r[i-1];
                    end
                end
            end

            // The entry at the tail is still pending until it lands, so a
            // flush on its landing edge cancels it as well.
            assign tail_vld = vld_r[DEPTH-1] & ~flush;
            assign tail_dat = dat_r[DEPTH-1];
            assign busy     = |vld_r;
        end
    endgenerate

endmodule

// File: rtl/dff_bank.sv
// Bank of WIDTH emulated D flip-flops with per-channel preset/clear.
// Latency: D to Q DLY_D clk cycles after capture; Sn/Cn to Q DLY_PS cycles.
// Backpressure: none; a capture can be taken every clk cycle.
module dff_bank
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DLY_D     = 2,
    parameter int               DLY_PS    = 0,
    parameter int               EDGE_MODE = 1,
    parameter logic [WIDTH-1:0] INIT      = '0
) (
    input  logic             clk,
    input  logic             Rn,
    input  logic             ck,
    input  logic             ce,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Sn,
    input  logic [WIDTH-1:0] Cn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             busy
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("dff_bank: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
        end
        if (DLY_D < 0 || DLY_D > int'(MAX_DLY)) begin : g_bad_dly_d
            $error("dff_bank: DLY_D %0d outside 0..%0d", DLY_D, MAX_DLY);
        end
        if (DLY_PS < 0 || DLY_PS > DLY_D) begin : g_bad_dly_ps
            $error("dff_bank: DLY_PS %0d must be within 0..DLY_D (%0d)", DLY_PS, DLY_D);
        end
        if (EDGE_MODE != EDGE && EDGE_MODE != STROBE) begin : g_bad_mode
            $error("dff_bank: EDGE_MODE %0d is neither EDGE nor STROBE", EDGE_MODE);
        end
    endgenerate

    logic             ck_q;
    logic             cap;
    logic [WIDTH-1:0] keep;
    logic [WIDTH-1:0] flush;
    logic [WIDTH-1:0] cap_vld;
    logic [WIDTH-1:0] land_vld;
    logic [WIDTH-1:0] land_dat;
    logic [WIDTH-1:0] line_busy;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] qn_nxt;
    logic [WIDTH-1:0] unused_ovr_vld;
    logic [WIDTH-1:0] unused_ovr_busy;
    logic [1:0]       ovr_dat [WIDTH];

    // Registered copy of the chip clock. Reset loads the live level too,
    // so a ck already high when reset is released is not seen as an edge.
    always_ff @(posedge clk) begin
        ck_q <= ck;
    end

    assign cap = (EDGE_MODE == EDGE) ? (ck & ~ck_q) : ce;

    // A channel with either override pin low ignores the capture and
    // cancels everything it still has in flight.
    assign keep    = Sn & Cn;
    assign flush   = ~keep;
    assign cap_vld = {WIDTH{cap}} & keep;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            ovr_t ovr;

            dly_line #(
                .DEPTH   (DLY_D),
                .W       (1),
                .RST_DAT (1'b0)
            ) u_data (
                .clk      (clk),
                .rn       (Rn),
                .flush    (flush[i]),
                .vld      (cap_vld[i]),
                .dat      (D[i]),
                .tail_vld (land_vld[i]),
                .tail_dat (land_dat[i]),
                .busy     (line_busy[i])
            );

            // Override pins are resampled every cycle; reset fills the
            // line with the released (1,1) pair.
            dly_line #(
                .DEPTH   (DLY_PS),
                .W       (2),
                .RST_DAT (2'b11)
            ) u_ovr (
                .clk      (clk),
                .rn       (Rn),
                .flush    (1'b0),
                .vld      (1'b1),
                .dat      ({Sn[i], Cn[i]}),
                .tail_vld (unused_ovr_vld[i]),
                .tail_dat (ovr_dat[i]),
                .busy     (unused_ovr_busy[i])
            );

            assign ovr = ovr_decode(ovr_dat[i][1], ovr_dat[i][0]);

            // Override beats landing data; with neither, Q holds and Qn
            // recovers to ~Q (this is how a both-low release settles).
            assign q_nxt[i]  = ovr.frc ? ovr.q  : (land_vld[i] ? land_dat[i] : Q[i]);
            assign qn_nxt[i] = ovr.frc ? ovr.qn : ~q_nxt[i];
        end
    endgenerate

    // Output register for all channels.
    always_ff @(posedge clk) begin
        if (!Rn) begin
            Q  <= INIT;
            Qn <= ~INIT;
        end else begin
            Q  <= q_nxt;
            Qn <= qn_nxt;
        end
    end

    assign busy = |line_busy;

endmodule

// File: tb/tb_dff_bank.sv
// Bench for dff_bank: two instances (edge mode and strobe mode) checked
// every cycle against a schedule-based model, plus targeted scenarios.
// Inputs change 1 time unit after a rising clk edge and are stable at the next.
module tb_dff_bank;

    logic       clk;
    logic       rn, ck, ce;
    logic [7:0] d, sn, cn;
    logic [7:0] q_a, qn_a, q_b, qn_b;
    logic       busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dff_bank #(
        .WIDTH(8), .DLY_D(2), .DLY_PS(0), .EDGE_MODE(1), .INIT(8'hA5)
    ) u_a (
        .clk(clk), .Rn(rn), .ck(ck), .ce(ce), .D(d), .Sn(sn), .Cn(cn),
        .Q(q_a), .Qn(qn_a), .busy(busy_a)
    );

    dff_bank #(
        .WIDTH(8), .DLY_D(1), .DLY_PS(1), .EDGE_MODE(0), .INIT(8'h0F)
    ) u_b (
        .clk(clk), .Rn(rn), .ck(ck), .ce(ce), .D(d), .Sn(sn), .Cn(cn),
        .Q(q_b), .Qn(qn_b), .busy(busy_b)
    );

    // Model parameters, index 0 = u_a, 1 = u_b.
    int         m_dly_d  [2] = '{2, 1};
    int         m_dly_ps [2] = '{0, 1};
    int         m_edge   [2] = '{1, 0};
    logic [7:0] m_init   [2] = '{8'hA5, 8'h0F};

    // Model state: outputs, previous ck, a landing schedule indexed by the
    // cycle a capture is due (mod 16), and a history of Sn/Cn by cycle.
    logic [7:0] mq   [2];
    logic [7:0] mqn  [2];
    logic       mbusy[2];
    logic       mckp [2];
    bit         pv   [2][8][16];
    bit         pd   [2][8][16];
    logic [1:0] oh   [2][8][16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input int k);
        int         now_s, old_s, land_s;
        logic       cap;
        logic [1:0] eff;
        bit         land, val;
        now_s = cyc % 16;
        if (!rn) begin
            mq[k]    = m_init[k];
            mqn[k]   = ~m_init[k];
            mbusy[k] = 1'b0;
            mckp[k]  = ck;
            for (int ch = 0; ch < 8; ch++) begin
                for (int s = 0; s < 16; s++) begin
                    pv[k][ch][s] = 1'b0;
                    oh[k][ch][s] = 2'b11;
                end
            end
        end else begin
            cap     = (m_edge[k] != 0) ? (ck && !mckp[k]) : ce;
            mckp[k] = ck;
            old_s   = (cyc - m_dly_ps[k] + 16) % 16;
            land_s  = (cyc + m_dly_d[k]) % 16;
            for (int ch = 0; ch < 8; ch++) begin
                oh[k][ch][now_s] = {sn[ch], cn[ch]};
                if (!(sn[ch] && cn[ch])) begin
                    for (int s = 0; s < 16; s++) pv[k][ch][s] = 1'b0;
                end else if (cap) begin
                    pv[k][ch][land_s] = 1'b1;
                    pd[k][ch][land_s] = d[ch];
                end
                land = pv[k][ch][now_s];
                val  = pd[k][ch][now_s];
                pv[k][ch][now_s] = 1'b0;
                eff = oh[k][ch][old_s];
                case (eff)
                    2'b01:   begin mq[k][ch] = 1'b1; mqn[k][ch] = 1'b0; end
                    2'b10:   begin mq[k][ch] = 1'b0; mqn[k][ch] = 1'b1; end
                    2'b00:   begin mq[k][ch] = 1'b1; mqn[k][ch] = 1'b1; end
                    default: begin
                        if (land) mq[k][ch] = val;
                        mqn[k][ch] = ~mq[k][ch];
                    end
                endcase
            end
            mbusy[k] = 1'b0;
            for (int ch = 0; ch < 8; ch++) begin
                for (int s = 0; s < 16; s++) mbusy[k] = mbusy[k] | pv[k][ch][s];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge(0);
        model_edge(1);
        cyc++;
        chk("a_q",    32'(q_a),    32'(mq[0]));
        chk("a_qn",   32'(qn_a),   32'(mqn[0]));
        chk("a_busy", 32'(busy_a), 32'(mbusy[0]));
        chk("b_q",    32'(q_b),    32'(mq[1]));
        chk("b_qn",   32'(qn_b),   32'(mqn[1]));
        chk("b_busy", 32'(busy_b), 32'(mbusy[1]));
    endtask

    initial begin
        rn = 1'b0; ck = 1'b1; ce = 1'b0; d = 8'h00; sn = 8'hFF; cn = 8'hFF;

        // Reset with ck high through release.
        repeat (2) step();
        chk("rst_q_a",    32'(q_a),    32'h0A5);
        chk("rst_qn_a",   32'(qn_a),   32'h05A);
        chk("rst_busy_a", 32'(busy_a), 32'h0);
        chk("rst_q_b",    32'(q_b),    32'h00F);
        chk("rst_qn_b",   32'(qn_b),   32'h0F0);
        rn = 1'b1;
        step();
        chk("exit_noedge_q_a",    32'(q_a),    32'h0A5);
        chk("exit_noedge_busy_a", 32'(busy_a), 32'h0);

        // One rising ck edge, DLY_D=2.
        ck = 1'b0; step();
        ck = 1'b1; d = 8'h3C; step();
        chk("lat_busy_t", 32'(busy_a), 32'h1);
        step();
        chk("lat_busy_t1", 32'(busy_a), 32'h1);
        chk("lat_q_t1",    32'(q_a),    32'h0A5);
        step();
        chk("lat_q_t2",    32'(q_a),    32'h03C);
        chk("lat_qn_t2",   32'(qn_a),   32'h0C3);
        chk("lat_busy_t2", 32'(busy_a), 32'h0);

        // Preset on channel 0 cancels its in-flight capture.
        ck = 1'b0; step();
        ck = 1'b1; d = 8'hFF; step();
        sn = 8'hFE; step();
        chk("pre_q_t1", 32'(q_a), 32'h03D);
        sn = 8'hFF; step();
        chk("pre_q_t2", 32'(q_a), 32'h0FF);

        // Clear on channel 0 cancels a pending 1 on that channel.
        ck = 1'b0; step();
        ck = 1'b1; d = 8'h01; step();
        cn = 8'hFE; step();
        chk("clr_q_t1", 32'(q_a), 32'h0FE);
        cn = 8'hFF; step();
        chk("clr_q_t2",  32'(q_a),  32'h000);
        chk("clr_qn_t2", 32'(qn_a), 32'h0FF);

        // Both low on channel 3, then staggered release.
        sn = 8'hF7; cn = 8'hF7; step();
        chk("both_q3",  32'(q_a[3]),  32'h1);
        chk("both_qn3", 32'(qn_a[3]), 32'h1);
        sn = 8'hFF; step();
        chk("relsn_q3",  32'(q_a[3]),  32'h0);
        chk("relsn_qn3", 32'(qn_a[3]), 32'h1);
        cn = 8'hFF; step();
        chk("relcn_q3",  32'(q_a[3]),  32'h0);
        chk("relcn_qn3", 32'(qn_a[3]), 32'h1);
        repeat (2) step();

        // Strobe mode, back-to-back captures, DLY_D=1.
        ce = 1'b1; d = 8'h01; step();
        d = 8'h02; step();
        chk("stb_q1", 32'(q_b), 32'h001);
        d = 8'h03; step();
        chk("stb_q2", 32'(q_b), 32'h002);
        ce = 1'b0; step();
        chk("stb_q3", 32'(q_b), 32'h003);

        // Reset while a strobe capture is in flight.
        ce = 1'b1; d = 8'h44; step();
        d = 8'h55; step();
        chk("fly_busy_b", 32'(busy_b), 32'h1);
        rn = 1'b0; ce = 1'b0; step();
        chk("midrst_q_b",    32'(q_b),    32'h00F);
        chk("midrst_busy_b", 32'(busy_b), 32'h0);
        chk("midrst_q_a",    32'(q_a),    32'h0A5);
        rn = 1'b1; d = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_nostale_b", 32'(q_b), 32'h00F);
        end

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            rn = ($urandom_range(0, 63) != 0);
            ck = 1'($urandom_range(0, 1));
            ce = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                sn[i] = ($urandom_range(0, 7) != 0);
                cn[i] = ($urandom_range(0, 7) != 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
